number_serial_tx: RTL and testbench



---
 rtl/number_pkg.sv | 10 +
 rtl/number_serial_tx_bit_timer.sv | 23 ++
 rtl/number_serial_tx.sv | 103 ++++++++++
 tb/tb_number_serial_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/number_pkg.sv
// number_pkg: shared types and constants for the number-analysis serial transmitter.
package number_pkg;

    localparam int WIDTH = 32;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

endpackage

// File: rtl/number_serial_tx_bit_timer.sv
// tx_bit_timer: divides the clock into line-bit periods, strobing on the last cycle of each.
module tx_bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic load_i,
    output logic bit_tick_o
);

    localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_tick_o = run_i && cnt_q == CW'(BIT_CYCLES - 1);
    assign cnt_d = (load_i || !run_i || bit_tick_o) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

endmodule

// File: rtl/number_serial_tx.sv
// number_serial_tx: frames 32-bit operands LSB-first with start, even-parity and stop bits,
// behind a one-word holding register so frames can run back-to-back.
module number_serial_tx #(
    parameter int WIDTH      = number_pkg::WIDTH,
    parameter int BIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx_line,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             odd_flag
);

    import number_pkg::*;

    localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;

    tx_state_t        state_q;
    logic [WIDTH-1:0] hold_q, shift_q;
    logic [BW-1:0]    bit_q;
    logic             hold_full_q, parity_q, line_q, busy_q, odd_q;
    logic             tick, load, accept;

    assign accept = in_valid && !hold_full_q;
    assign load   = hold_full_q && (state_q == IDLE || (state_q == STOP && tick));

    tx_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (state_q != IDLE),
        .load_i     (load),
        .bit_tick_o (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            shift_q     <= '0;
            bit_q       <= '0;
            hold_full_q <= 1'b0;
            parity_q    <= 1'b0;
            line_q      <= IDLE_LEVEL;
            busy_q      <= 1'b0;
            odd_q       <= 1'b0;
        end else begin
            if (accept) begin
                hold_q      <= in_data;
                hold_full_q <= 1'b1;
            end else if (load) begin
                hold_full_q <= 1'b0;
            end
            if (load) begin
                state_q  <= START;
                shift_q  <= hold_q;
                parity_q <= ^hold_q;
                odd_q    <= hold_q[0];
                line_q   <= START_LEVEL;
                busy_q   <= 1'b1;
                bit_q    <= '0;
            end else if (tick) begin
                case (state_q)
                    START: begin
                        state_q <= DATA;
                        line_q  <= shift_q[0];
                    end
                    DATA: begin
                        if (bit_q == BW'(WIDTH - 1)) begin
                            state_q <= PARITY;
                            line_q  <= parity_q;
                        end else begin
                            // line already shows shift_q[0]; expose the next bit as we shift
                            shift_q <= shift_q >> 1;
                            line_q  <= shift_q[1];
                            bit_q   <= bit_q + 1'b1;
                        end
                    end
                    PARITY: begin
                        state_q <= STOP;
                        line_q  <= IDLE_LEVEL;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // tx_done is decoded from registered state and timer only, never from the inputs
    assign tx_done  = state_q == STOP && tick;
    assign in_ready = !hold_full_q;
    assign tx_line  = line_q;
    assign tx_busy  = busy_q;
    assign odd_flag = odd_q;

endmodule

// File: tb/tb_number_serial_tx.sv
// tb_number_serial_tx: frame-position model scoreboard plus directed literal checks
// for the BIT_CYCLES=4 transmitter and a BIT_CYCLES=1 instance.
module tb_number_serial_tx;

    localparam int W = 32;
    localparam int FL4 = (W + 3) * 4;
    localparam int FL1 = (W + 3) * 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] in_data = '0, in_data1 = '0;
    logic in_valid = 1'b0, in_valid1 = 1'b0;
    logic in_ready, tx_line, tx_busy, tx_done, odd_flag;
    logic in_ready1, tx_line1, tx_busy1, tx_done1, odd_flag1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    number_serial_tx #(.WIDTH(W), .BIT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx_line(tx_line), .tx_busy(tx_busy),
        .tx_done(tx_done), .odd_flag(odd_flag)
    );

    number_serial_tx #(.WIDTH(W), .BIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .tx_line(tx_line1), .tx_busy(tx_busy1),
        .tx_done(tx_done1), .odd_flag(odd_flag1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line level at cycle p of a frame carrying w, measured from the START edge.
    function automatic logic frame_bit(input logic [W-1:0] w, input int p, input int bc);
        int b;
        b = p / bc;
        if (b == 0) return 1'b0;
        if (b <= W) return w[b-1];
        if (b == W + 1) return ^w;
        return 1'b1;
    endfunction

    // Behavioural model: a holding slot and a frame position counter.
    logic [W-1:0] m_hold, m_word;
    logic m_full, m_active, m_odd;
    int m_p;

    always @(posedge clk or negedge rst_n) begin
        logic acc, ld;
        if (!rst_n) begin
            m_full = 0; m_active = 0; m_odd = 0; m_p = 0; m_hold = '0; m_word = '0;
        end else begin
            acc = in_valid && !m_full;
            ld = m_full && (!m_active || m_p == FL4 - 1);
            if (m_active && !ld) begin
                if (m_p == FL4 - 1) m_active = 0;
                else m_p++;
            end
            if (ld) begin
                m_active = 1; m_p = 0; m_word = m_hold; m_odd = m_hold[0]; m_full = 0;
            end
            if (acc) begin
                m_full = 1; m_hold = in_data;
            end
        end
    end

    always @(negedge clk) begin
        chk("sb_line", tx_line, m_active ? frame_bit(m_word, m_p, 4) : 1'b1);
        chk("sb_busy", tx_busy, m_active);
        chk("sb_done", tx_done, m_active && m_p == FL4 - 1);
        chk("sb_odd", odd_flag, m_odd);
        chk("sb_ready", in_ready, !m_full);
    end

    logic cap_line [0:199];
    logic cap_done [0:199];
    logic cap_odd;

    // Offers w until accepted, then records n cycles starting at the START cycle.
    task automatic send(input logic [W-1:0] w, input int n);
        logic r;
        int k;
        @(posedge clk); #2;
        in_data = w; in_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk); r = in_ready;
            @(posedge clk); k++;
        end while (!r && k < 1000);
        if (!r) chk("accept_timeout", 0, 1);
        #2 in_valid = 1'b0;
        @(negedge clk);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            cap_line[c] = tx_line;
            cap_done[c] = tx_done;
            if (c == 0) cap_odd = odd_flag;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (tx_busy && k < 1000) begin @(negedge clk); k++; end
        chk("idle_timeout", tx_busy, 0);
        @(negedge clk);
    endtask

    function automatic int count_ones(input int lo, input int hi);
        int s;
        s = 0;
        for (int c = lo; c <= hi; c++) s += int'(cap_line[c]);
        return s;
    endfunction

    function automatic int done_at();
        for (int c = 0; c < 200; c++) if (cap_done[c]) return c;
        return -1;
    endfunction

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic r;
        int n;
        #23 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_line", tx_line, 1);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_odd", odd_flag, 0);

        send(32'hFFFF_FFFF, FL4);
        chk("ff_start", count_ones(0, 3), 0);
        chk("ff_data_ones", count_ones(4, 131), 128);
        chk("ff_parity", cap_line[132], 0);
        chk("ff_stop", count_ones(136, 139), 4);
        chk("ff_odd", cap_odd, 1);
        chk("ff_done_cycle", done_at(), 139);
        wait_idle();

        send(32'hFFFF_FFFE, FL4);
        chk("fe_bit0", count_ones(4, 7), 0);
        chk("fe_bit1", count_ones(8, 11), 4);
        chk("fe_parity", cap_line[132], 1);
        chk("fe_odd", cap_odd, 0);
        wait_idle();

        send(32'h0000_0000, FL4);
        chk("zero_data_ones", count_ones(4, 131), 0);
        chk("zero_parity", cap_line[132], 0);
        chk("zero_odd", cap_odd, 0);
        wait_idle();

        // back-to-back with a third word stalled behind a full holding register
        @(posedge clk); #2;
        in_data = 32'h8000_0001; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk); r = in_ready;
            @(posedge clk); n++;
        end while (!r && n < 1000);
        #2 in_data = 32'hD261_864B;
        n = 0;
        do begin
            @(negedge clk); r = in_ready;
            @(posedge clk); n++;
        end while (!r && n < 1000);
        chk("b2b_second_accept", n, 2);
        #2 in_data = 32'h1234_5678;
        @(negedge clk);
        chk("full_ready_low", in_ready, 0);
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk); r = in_ready;
        end while (!r && n < 1000);
        // ready rises after the load edge of frame 2; the third word is taken on the next edge
        chk("third_waits_frame2", n, 139);
        @(posedge clk); #2 in_valid = 1'b0;
        wait_idle();

        // reset mid-DATA with a word waiting in the holding register
        send(32'hA5A5_A5A5, 4 * 11 + 2);
        @(posedge clk); #2;
        in_data = 32'h0F0F_0F0F; in_valid = 1'b1;
        @(posedge clk); #2 in_valid = 1'b0;
        @(negedge clk);
        chk("mid_hold_full", in_ready, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_line", tx_line, 1);
        chk("arst_busy", tx_busy, 0);
        chk("arst_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_word_dropped", tx_busy, 0);
        send(32'h0000_0003, FL4);
        chk("post_rst_odd", cap_odd, 1);
        chk("post_rst_done_cycle", done_at(), 139);
        wait_idle();

        // BIT_CYCLES=1 instance
        @(posedge clk); #2;
        in_data1 = 32'h0000_000F; in_valid1 = 1'b1;
        n = 0;
        do begin
            @(negedge clk); r = in_ready1;
            @(posedge clk); n++;
        end while (!r && n < 1000);
        #2 in_valid1 = 1'b0;
        @(negedge clk);
        n = 0;
        for (int c = 0; c < FL1 + 1; c++) begin
            @(negedge clk);
            if (c < FL1 && tx_line1 !== frame_bit(32'h0000_000F, c, 1)) n++;
            cap_done[c] = tx_done1;
            cap_line[c] = tx_busy1;
        end
        chk("bc1_line_errors", n, 0);
        chk("bc1_done_cycle", done_at(), 34);
        chk("bc1_busy_last", cap_line[34], 1);
        chk("bc1_busy_after", cap_line[35], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
